seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Iterative RV32M multiplier: radix-2 carry-save accumulation of two multiplier
// bits per cycle, followed by a single carry-propagate resolve cycle.

module carry_save_adder #(
  parameter int W = 68
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  logic [W-2:0] maj_s;

  assign s     = x ^ y ^ z;
  assign maj_s = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
  // The shifted-out carry LSB is free, so it carries the +1 of a two's-complement negation.
  assign c     = {maj_s, cin};
endmodule

module seq_multiplier (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [1:0]  op_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [3:0]  tag_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [31:0] result_out,
  output logic [3:0]  tag_out
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_r;
  logic        ready_r;
  logic        valid_r;
  logic [1:0]  op_r;
  logic [3:0]  tag_r;
  logic [3:0]  tag_out_r;
  logic [31:0] result_r;
  logic [33:0] a_r;
  logic [33:0] b_r;
  logic [67:0] sum_r;
  logic [67:0] carry_r;
  logic [4:0]  cnt_r;

  logic [5:0]  j0_s;
  logic [5:0]  j1_s;
  logic        m0_s;
  logic        m1_s;
  logic        neg_s;
  logic [67:0] a_ext_s;
  logic [67:0] pp0_s;
  logic [67:0] pp1_raw_s;
  logic [67:0] pp1_s;
  logic [67:0] s0_s;
  logic [67:0] c0_s;
  logic [67:0] s1_s;
  logic [67:0] c1_s;
  logic [63:0] prod_s;

  assign j0_s      = {cnt_r, 1'b0};
  assign j1_s      = {cnt_r, 1'b1};
  assign m0_s      = b_r[j0_s];
  assign m1_s      = b_r[j1_s];
  assign a_ext_s   = {{34{a_r[33]}}, a_r};
  assign pp0_s     = m0_s ? (a_ext_s << j0_s) : 68'd0;
  assign pp1_raw_s = a_ext_s << j1_s;
  // Multiplier bit 33 is the sign position of the 34-bit operand, so it subtracts.
  assign neg_s     = m1_s && (cnt_r == 5'd16);
  assign pp1_s     = m1_s ? (neg_s ? ~pp1_raw_s : pp1_raw_s) : 68'd0;

  carry_save_adder #(.W(68)) u_csa0 (
    .x(sum_r), .y(carry_r), .z(pp0_s), .cin(1'b0), .s(s0_s), .c(c0_s)
  );

  carry_save_adder #(.W(68)) u_csa1 (
    .x(s0_s), .y(c0_s), .z(pp1_s), .cin(neg_s), .s(s1_s), .c(c1_s)
  );

  assign prod_s = sum_r[63:0] + carry_r[63:0];

  assign ready_out  = ready_r;
  assign valid_out  = valid_r;
  assign result_out = result_r;
  assign tag_out    = tag_out_r;

  // Control FSM, operand latch, carry-save accumulator and result registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      op_r      <= 2'd0;
      tag_r     <= 4'd0;
      tag_out_r <= 4'd0;
      result_r  <= 32'd0;
      a_r       <= 34'd0;
      b_r       <= 34'd0;
      sum_r     <= 68'd0;
      carry_r   <= 68'd0;
      cnt_r     <= 5'd0;
    end else if (flush_in) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else if (!rdy_in) begin
      state_r <= state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_in) begin
            op_r    <= op_in;
            tag_r   <= tag_in;
            a_r     <= (op_in != 2'b11) ? {{2{rs1_in[31]}}, rs1_in} : {2'b00, rs1_in};
            b_r     <= op_in[1] ? {2'b00, rs2_in} : {{2{rs2_in[31]}}, rs2_in};
            sum_r   <= 68'd0;
            carry_r <= 68'd0;
            cnt_r   <= 5'd0;
            state_r <= ACCUM;
            ready_r <= 1'b0;
          end
        end
        ACCUM: begin
          sum_r   <= s1_s;
          carry_r <= c1_s;
          if (cnt_r == 5'd16) begin
            state_r <= RESOLVE;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        RESOLVE: begin
          result_r  <= (op_r == 2'b00) ? prod_s[31:0] : prod_s[63:32];
          tag_out_r <= tag_r;
          valid_r   <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
